// File: rtl/mem_sequencer_if.sv
// External memory bus of the sticky core: strobes and segment selects from the
// sequencer, acknowledge and read data from memory.
interface mem_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 8,
    parameter int OFF_W  = 16
) ();
    logic                   ready;
    logic [DATA_W-1:0]      data_in;
    logic                   load;
    logic                   store;
    logic                   code_seg;
    logic                   data_seg;
    logic                   stack_seg;
    logic [SEG_W+OFF_W-1:0] addr_out;
    logic [DATA_W-1:0]      data_out;

    modport master (
        input  ready, data_in,
        output load, store, code_seg, data_seg, stack_seg, addr_out, data_out
    );

    modport slave (
        output ready, data_in,
        input  load, store, code_seg, data_seg, stack_seg, addr_out, data_out
    );
endinterface

// File: rtl/mem_sequencer.sv
// Memory-side sequencer: arbitrates the single bus between instruction prefetch
// and CPU load/store, and hands whole instructions to decode.
module mem_sequencer #(
    parameter int               DATA_W     = 16,
    parameter int               SEG_W      = 8,
    parameter int               OFF_W      = 16,
    parameter int               INSN_WORDS = 2,
    parameter int               PQ_DEPTH   = 4,
    parameter logic [OFF_W-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    mem_sequencer_if.master              bus,
    input  logic [SEG_W-1:0]             cs,
    input  logic [SEG_W-1:0]             ds,
    input  logic [SEG_W-1:0]             ss,
    output logic                         insn_valid,
    output logic [DATA_W*INSN_WORDS-1:0] insn_out,
    input  logic                         insn_take,
    input  logic                         flush,
    input  logic [OFF_W-1:0]             flush_pc,
    input  logic                         ls_req,
    input  logic                         ls_write,
    input  logic                         ls_stack,
    input  logic [OFF_W-1:0]             ls_addr,
    input  logic [DATA_W-1:0]            ls_wdata,
    output logic                         ls_done,
    output logic [DATA_W-1:0]            ls_rdata
);

    // A depth-1 queue still gets a 1-bit pointer; the mask keeps it at 0.
    localparam int PW = (PQ_DEPTH > 1) ? $clog2(PQ_DEPTH) : 1;
    localparam int CW = $clog2(PQ_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MASK = PW'(PQ_DEPTH - 1);
    localparam logic [PW-1:0] POP_STEP = PW'(INSN_WORDS % PQ_DEPTH);
    localparam logic [CW-1:0] INSN_CNT = CW'(INSN_WORDS);
    localparam logic [CW-1:0] FULL_CNT = CW'(PQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_fetch;
    logic              start_data;
    logic              fetch_done;
    logic              data_done;

    logic [OFF_W-1:0]  fptr;
    logic              stale;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] pq_mem [0:(1<<PW)-1];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    assign insn_valid = (count >= INSN_CNT);
    // A fetch that saw a flush (now or earlier) still finishes on the bus but its word is dropped.
    assign push       = fetch_done && !stale && !flush;
    assign pop        = insn_take && insn_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        start_data  = 1'b0;
        fetch_done  = 1'b0;
        data_done   = 1'b0;
        unique case (state)
            IDLE: begin
                // ls_req is still high during the ls_done cycle; that is the old request.
                if (ls_req && !ls_done) begin
                    state_nxt  = DATA;
                    start_data = 1'b1;
                end else if ((count < FULL_CNT) && !flush) begin
                    state_nxt   = FETCH;
                    start_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (bus.ready) begin
                    state_nxt  = IDLE;
                    fetch_done = 1'b1;
                end
            end
            DATA: begin
                if (bus.ready) begin
                    state_nxt = IDLE;
                    data_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are captured on entry and held until the access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.load      <= 1'b0;
            bus.store     <= 1'b0;
            bus.code_seg  <= 1'b0;
            bus.data_seg  <= 1'b0;
            bus.stack_seg <= 1'b0;
            bus.addr_out  <= '0;
            bus.data_out  <= '0;
        end else if (start_fetch) begin
            bus.load      <= 1'b1;
            bus.store     <= 1'b0;
            bus.code_seg  <= 1'b1;
            bus.data_seg  <= 1'b0;
            bus.stack_seg <= 1'b0;
            bus.addr_out  <= {cs, fptr};
        end else if (start_data) begin
            bus.load      <= ~ls_write;
            bus.store     <= ls_write;
            bus.code_seg  <= 1'b0;
            bus.data_seg  <= ~ls_stack;
            bus.stack_seg <= ls_stack;
            bus.addr_out  <= {(ls_stack ? ss : ds), ls_addr};
            bus.data_out  <= ls_wdata;
        end else if (fetch_done || data_done) begin
            bus.load      <= 1'b0;
            bus.store     <= 1'b0;
            bus.code_seg  <= 1'b0;
            bus.data_seg  <= 1'b0;
            bus.stack_seg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fptr     <= RESET_PC;
            stale    <= 1'b0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
        end else begin
            ls_done <= data_done;
            if (data_done && bus.load) begin
                ls_rdata <= bus.data_in;
            end
            if (flush) begin
                fptr <= flush_pc;
            end else if (push) begin
                fptr <= fptr + OFF_W'(1);
            end
            if (fetch_done) begin
                stale <= 1'b0;
            end else if ((state == FETCH) && flush) begin
                stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + PW'(1)) & PTR_MASK;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr + POP_STEP) & PTR_MASK;
            end
            count <= count + CW'(push) - (pop ? INSN_CNT : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pq_mem[wr_ptr] <= bus.data_in;
        end
    end

    // Oldest word lands in the most significant slot.
    always_comb begin
        insn_out = '0;
        for (int i = 0; i < INSN_WORDS; i++) begin
            insn_out[DATA_W*(INSN_WORDS-i)-1 -: DATA_W] = pq_mem[(rd_ptr + PW'(i)) & PTR_MASK];
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: transaction-level model of queue, fetch pointer and
// data requests, plus directed scenarios with hand-computed values.
module tb_mem_sequencer;
    localparam int DATA_W = 16;
    localparam int SEG_W  = 8;
    localparam int OFF_W  = 16;
    localparam int IW     = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cs, ds, ss;
    logic        insn_valid;
    logic [31:0] insn_out;
    logic        insn_take, flush;
    logic [15:0] flush_pc;
    logic        ls_req, ls_write, ls_stack;
    logic [15:0] ls_addr, ls_wdata;
    logic        ls_done;
    logic [15:0] ls_rdata;

    mem_sequencer_if #(.DATA_W(DATA_W), .SEG_W(SEG_W), .OFF_W(OFF_W)) bus ();

    mem_sequencer #(
        .DATA_W(DATA_W), .SEG_W(SEG_W), .OFF_W(OFF_W),
        .INSN_WORDS(IW), .PQ_DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cs(cs), .ds(ds), .ss(ss),
        .insn_valid(insn_valid), .insn_out(insn_out), .insn_take(insn_take),
        .flush(flush), .flush_pc(flush_pc),
        .ls_req(ls_req), .ls_write(ls_write), .ls_stack(ls_stack),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] word_of(input logic [23:0] a);
        return a[15:0] ^ 16'hA5A5 ^ {8'h00, a[23:16]};
    endfunction

    // Memory responder: lat==0 ties ready high, else ready after lat strobe cycles.
    int lat  = 0;
    int wcnt = 0;
    initial begin
        bus.ready   = 1'b1;
        bus.data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.load || bus.store) begin
                bus.ready = (lat == 0) || (wcnt >= lat);
                wcnt++;
            end else begin
                wcnt = 0;
                bus.ready = (lat == 0);
            end
            bus.data_in = word_of(bus.addr_out);
        end
    end

    // Reference model: instruction words in program order, fetch offset, data results.
    logic [15:0] m_q[$];
    logic [15:0] m_fptr = 16'h0000;
    logic [15:0] m_rdata = 16'h0000;
    bit m_drop = 0, m_exp_done = 0, m_cont = 0, m_done_edge = 0, m_idle_req = 0;
    bit m_strobe, m_fin, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_fptr = 16'h0000; m_rdata = 16'h0000;
            m_drop = 0; m_exp_done = 0; m_cont = 0; m_done_edge = 0; m_idle_req = 0;
        end else begin
            m_strobe   = bus.load || bus.store;
            m_fin      = m_strobe && bus.ready;
            m_pop      = insn_take && (m_q.size() >= IW) && !flush;
            m_exp_done = m_fin && !bus.code_seg;
            if (m_fin && !bus.code_seg && bus.load)
                m_rdata = word_of({(ls_stack ? ss : ds), ls_addr});
            if (m_pop) repeat (IW) void'(m_q.pop_front());
            if (m_fin && bus.code_seg) begin
                if (!m_drop && !flush) begin
                    m_q.push_back(word_of({cs, m_fptr}));
                    m_fptr = m_fptr + 16'h0001;
                end
                m_drop = 0;
            end else if (m_strobe && bus.code_seg && flush) begin
                m_drop = 1;
            end
            if (flush) begin
                m_q.delete();
                m_fptr = flush_pc;
            end
            m_cont      = m_strobe && !bus.ready;
            m_done_edge = m_fin;
            m_idle_req  = !m_strobe && ls_req && !ls_done;
        end
    end

    logic [4:0]  s_flags = '0, c_flags;
    logic [23:0] s_addr = '0;
    logic [15:0] s_dout = '0;

    always @(negedge clk) begin
        if (!rst) begin
            c_flags = {bus.load, bus.store, bus.code_seg, bus.data_seg, bus.stack_seg};
            chk("insn_valid", insn_valid, m_q.size() >= IW);
            if (m_q.size() >= IW) chk("insn_out", insn_out, {m_q[0], m_q[1]});
            chk("ls_done", ls_done, m_exp_done);
            chk("ls_rdata", ls_rdata, m_rdata);
            if (m_done_edge) begin
                chk("bus_release", c_flags, 5'b00000);
            end else if (m_cont) begin
                chk("hold_flags", c_flags, s_flags);
                chk("hold_addr", bus.addr_out, s_addr);
                chk("hold_dout", bus.data_out, s_dout);
            end else if (bus.load || bus.store) begin
                if (bus.code_seg) begin
                    chk("fetch_flags", c_flags, 5'b10100);
                    chk("fetch_addr", bus.addr_out, {cs, m_fptr});
                    chk("fetch_room", m_q.size() < DEPTH, 1'b1);
                    chk("fetch_prio", m_idle_req, 1'b0);
                end else begin
                    chk("data_req", ls_req, 1'b1);
                    chk("data_flags", c_flags, {!ls_write, ls_write, 1'b0, !ls_stack, ls_stack});
                    chk("data_addr", bus.addr_out, {(ls_stack ? ss : ds), ls_addr});
                    if (ls_write) chk("data_wdata", bus.data_out, ls_wdata);
                end
            end else begin
                chk("idle_flags", c_flags, 5'b00000);
            end
            s_flags = c_flags;
            s_addr  = bus.addr_out;
            s_dout  = bus.data_out;
        end
    end

    task automatic wait_rise(input int maxc, output bit ok);
        logic prev;
        prev = bus.load || bus.store;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((bus.load || bus.store) && !prev) begin
                ok = 1;
                break;
            end
            prev = bus.load || bus.store;
        end
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (insn_valid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ls_done) begin ok = 1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hits;
        cs = 8'h12; ds = 8'h05; ss = 8'h7F;
        insn_take = 0; flush = 0; flush_pc = '0;
        ls_req = 0; ls_write = 0; ls_stack = 0; ls_addr = '0; ls_wdata = '0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("reset_flags", {bus.load, bus.store, bus.code_seg, bus.data_seg, bus.stack_seg}, 5'b00000);
        chk("reset_addr", bus.addr_out, 24'h000000);
        chk("reset_dout", bus.data_out, 16'h0000);
        chk("reset_insn_valid", insn_valid, 1'b0);
        chk("reset_ls", {ls_done, ls_rdata}, 17'h00000);
        @(posedge clk); #1 rst = 0;

        // Prefetch with ready tied high, then stall on a full queue.
        wait_rise(10, ok); chk("fetch0_seen", ok, 1'b1);
        chk("fetch0_addr", bus.addr_out, 24'h120000);
        wait_rise(10, ok); chk("fetch1_seen", ok, 1'b1);
        chk("fetch1_addr", bus.addr_out, 24'h120001);
        wait_valid(10, ok); chk("insn0_seen", ok, 1'b1);
        chk("insn0_value", insn_out, 32'hA5B7A5B6);
        repeat (20) @(negedge clk);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.load || bus.store) hits++;
        end
        chk("full_stall", hits, 0);
        chk("full_insn_value", insn_out, 32'hA5B7A5B6);

        // Stack load with slow memory while the queue is full.
        @(posedge clk); #1;
        lat = 3; ls_req = 1; ls_write = 0; ls_stack = 1; ls_addr = 16'h0040;
        wait_rise(10, ok); chk("load_seen", ok, 1'b1);
        chk("load_addr", bus.addr_out, 24'h7F0040);
        chk("load_flags", {bus.load, bus.store, bus.code_seg, bus.data_seg, bus.stack_seg}, 5'b10001);
        wait_done(20, ok); chk("load_done_seen", ok, 1'b1);
        chk("load_rdata", ls_rdata, 16'hA59A);
        @(posedge clk); #1 ls_req = 0;
        @(negedge clk); chk("load_done_pulse", ls_done, 1'b0);

        // Store via DS; a take frees room but fetch waits for the store to end.
        @(posedge clk); #1;
        ls_req = 1; ls_write = 1; ls_stack = 0; ls_addr = 16'hFFFF; ls_wdata = 16'hBEEF;
        wait_rise(10, ok); chk("store_seen", ok, 1'b1);
        chk("store_addr", bus.addr_out, 24'h05FFFF);
        chk("store_flags", {bus.load, bus.store, bus.code_seg, bus.data_seg, bus.stack_seg}, 5'b01010);
        chk("store_wdata", bus.data_out, 16'hBEEF);
        @(posedge clk); #1 insn_take = 1;
        @(posedge clk); #1 insn_take = 0;
        wait_done(20, ok); chk("store_done_seen", ok, 1'b1);
        @(posedge clk); #1 ls_req = 0; ls_write = 0;
        @(negedge clk);
        chk("resume_addr", bus.addr_out, 24'h120004);
        chk("resume_flags", {bus.load, bus.store, bus.code_seg, bus.data_seg, bus.stack_seg}, 5'b10100);

        // Flush while the fetch at offset 3 is in flight.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            wait_rise(20, ok);
            if (ok && bus.addr_out[15:0] == 16'h0003) break;
        end
        chk("fetch3_addr", bus.addr_out, 24'h120003);
        @(posedge clk); #1 flush = 1; flush_pc = 16'h0100;
        @(posedge clk); #1 flush = 0;
        @(negedge clk); chk("flush_clears", insn_valid, 1'b0);
        wait_rise(20, ok); chk("redirect_seen", ok, 1'b1);
        chk("redirect_addr", bus.addr_out, 24'h120100);
        chk("stale_dropped", insn_valid, 1'b0);
        wait_valid(30, ok); chk("redirect_valid", ok, 1'b1);
        chk("redirect_insn", insn_out, 32'hA4B7A4B6);

        // Offset wrap keeps the segment; flush together with take.
        @(posedge clk); #1 lat = 0; flush = 1; flush_pc = 16'hFFFF;
        @(posedge clk); #1 flush = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rise(10, ok);
            if (ok && bus.addr_out == 24'h12FFFF) break;
        end
        chk("wrap_last_addr", bus.addr_out, 24'h12FFFF);
        wait_rise(10, ok); chk("wrap_seen", ok, 1'b1);
        chk("wrap_addr", bus.addr_out, 24'h120000);
        wait_valid(10, ok); chk("wrap_valid", ok, 1'b1);
        chk("wrap_insn", insn_out, 32'h5A48A5B7);
        @(posedge clk); #1 flush = 1; insn_take = 1; flush_pc = 16'h0200;
        @(posedge clk); #1 flush = 0; insn_take = 0;
        @(negedge clk); chk("flush_beats_take", insn_valid, 1'b0);

        // Reset in the middle of a data load.
        @(posedge clk); #1;
        lat = 5; ls_req = 1; ls_write = 0; ls_stack = 0; ls_addr = 16'h0010;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.load && bus.data_seg) begin ok = 1; break; end
        end
        chk("rst_load_seen", ok, 1'b1);
        #2 rst = 1;
        #1;
        chk("rst_drops_load", {bus.load, bus.store, bus.data_seg}, 3'b000);
        chk("rst_no_done", ls_done, 1'b0);
        @(posedge clk); #1 ls_req = 0;
        @(posedge clk); #1 rst = 0;
        wait_rise(10, ok); chk("restart_seen", ok, 1'b1);
        chk("restart_addr", bus.addr_out, 24'h120000);
        chk("restart_no_done", ls_done, 1'b0);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
